// File: rtl/pwm_decoder_pkg.sv
// ----------------------------------------------------------------------------
// pwm_decoder_pkg
// Shared constants, types and the pulse-width/phase decode helper used by the
// PWM loop-back decoder and its per-channel edge capture cells.
//   PWM_PERIOD     cycles in one PWM period (TIME_CNT runs 0..PWM_PERIOD-1)
//   TIME_W         width of TIME_CNT, edge times and pulse widths
//   PHASE_W        width of the decoded phase (pulse centre / 2)
//   IDX_W          width of the output channel index
//   pwm_capture_t  per-channel capture record {rise_t, fall_t, level, edge_seen}
//   pwm_result_t   decoded word {pulse_width, phase, full_on}
// ----------------------------------------------------------------------------
package pwm_decoder_pkg;

    localparam int PWM_PERIOD = 512;
    localparam int TIME_W     = 9;
    localparam int PHASE_W    = 8;
    localparam int IDX_W      = 8;

    typedef struct packed {
        logic [TIME_W-1:0] rise_t;
        logic [TIME_W-1:0] fall_t;
        logic              level;
        logic              edge_seen;
    } pwm_capture_t;

    typedef struct packed {
        logic [TIME_W-1:0]  pulse_width;
        logic [PHASE_W-1:0] phase;
        logic               full_on;
    } pwm_result_t;

    typedef enum logic {
        ST_IDLE,
        ST_SEND
    } stream_state_t;

    // Turns one snapshotted capture record into the encoder-style word.
    // The 9-bit subtraction wraps naturally, so a pulse that straddles the
    // period boundary (fall_t < rise_t) needs no special handling.
    function automatic pwm_result_t decode_capture(input pwm_capture_t cap);
        pwm_result_t       res;
        logic [TIME_W-1:0] pw;
        logic [TIME_W-1:0] centre;
        res    = '0;
        pw     = cap.fall_t - cap.rise_t;
        centre = cap.rise_t + (pw >> 1);
        if (cap.edge_seen) begin
            res.pulse_width = pw;
            res.phase       = centre[TIME_W-1:1];
        end else if (cap.level) begin
            res.pulse_width = '1;
            res.full_on     = 1'b1;
        end
        return res;
    endfunction

endpackage

// File: rtl/pwm_decoder_if.sv
// ----------------------------------------------------------------------------
// pwm_decoder_if
// Serial result stream of the PWM decoder, one channel word per cycle.
//   pulse_width_out  decoded pulse width in cycles (0..511)
//   phase_out        decoded phase (pulse centre / 2)
//   full_on_out      channel was high for the whole period
//   dout_idx         channel index of the current word
//   dout_valid       word valid
//   overrun          sticky: a period boundary arrived while still streaming
// master = decoder side (drives), slave = consumer side (observes).
// ----------------------------------------------------------------------------
interface pwm_decoder_if;
    import pwm_decoder_pkg::*;

    logic [TIME_W-1:0]  pulse_width_out;
    logic [PHASE_W-1:0] phase_out;
    logic               full_on_out;
    logic [IDX_W-1:0]   dout_idx;
    logic               dout_valid;
    logic               overrun;

    modport master (
        output pulse_width_out,
        output phase_out,
        output full_on_out,
        output dout_idx,
        output dout_valid,
        output overrun
    );

    modport slave (
        input pulse_width_out,
        input phase_out,
        input full_on_out,
        input dout_idx,
        input dout_valid,
        input overrun
    );

endinterface

// File: rtl/pwm_edge_capture.sv
// ----------------------------------------------------------------------------
// pwm_edge_capture
// One observed PWM channel: registers the input level, detects rising and
// falling edges against it and latches the (latency-compensated) edge times.
//   clk       in   system clock
//   rst       in   synchronous active-high reset
//   time_cnt  in   PWM period counter
//   boundary  in   high in the last cycle of the period (time_cnt == 511)
//   pwm_in    in   PWM waveform under observation
//   cap_next  out  capture record including this cycle's edge; the top
//                  snapshots this at the boundary so edges in the boundary
//                  cycle still belong to the closing period
// ----------------------------------------------------------------------------
module pwm_edge_capture
    import pwm_decoder_pkg::*;
#(
    parameter int LATENCY_COMP = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [TIME_W-1:0] time_cnt,
    input  logic              boundary,
    input  logic              pwm_in,
    output pwm_capture_t      cap_next
);

    localparam logic [TIME_W-1:0] LAT = TIME_W'(LATENCY_COMP);

    pwm_capture_t      cap_q;
    logic [TIME_W-1:0] edge_time;

    // Edge time is pulled back by the register latency of the PWM path;
    // the 9-bit subtraction gives the mod-512 wrap for free.
    assign edge_time = time_cnt - LAT;

    // Apply this cycle's edge to the stored record. The latest edge of each
    // kind overwrites the older one; rise_t/fall_t otherwise persist.
    always_comb begin
        cap_next       = cap_q;
        cap_next.level = pwm_in;
        if (pwm_in != cap_q.level) begin
            cap_next.edge_seen = 1'b1;
            if (pwm_in) begin
                cap_next.rise_t = edge_time;
            end else begin
                cap_next.fall_t = edge_time;
            end
        end
    end

    // Register the record; edge_seen restarts empty for each new period
    // because the boundary cycle's view has already gone to the snapshot.
    always_ff @(posedge clk) begin
        if (rst) begin
            cap_q <= '0;
        end else begin
            cap_q           <= cap_next;
            cap_q.edge_seen <= cap_next.edge_seen & ~boundary;
        end
    end

endmodule

// File: rtl/pwm_decoder.sv
// ----------------------------------------------------------------------------
// pwm_decoder
// Loop-back monitor for the PWM stage: recovers pulse width and phase of each
// channel from its waveform against TIME_CNT and streams one word per channel
// after every period boundary.
//   clk       in   system clock (20.48 MHz domain)
//   rst       in   synchronous active-high reset
//   time_cnt  in   PWM period counter, 0..511
//   pwm_in    in   DEPTH PWM waveforms, bit i = channel i
//   dout      -    pwm_decoder_if.master result stream + sticky overrun
// Parameters: DEPTH channels, LATENCY_COMP cycles subtracted from edge times.
// ----------------------------------------------------------------------------
module pwm_decoder
    import pwm_decoder_pkg::*;
#(
    parameter int DEPTH        = 249,
    parameter int LATENCY_COMP = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [TIME_W-1:0] time_cnt,
    input  logic [DEPTH-1:0]  pwm_in,
    pwm_decoder_if.master     dout
);

    localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(DEPTH - 1);
    localparam logic [TIME_W-1:0] LAST_TIME = TIME_W'(PWM_PERIOD - 1);

    logic               boundary;
    pwm_capture_t       cap_next [DEPTH];
    pwm_capture_t       bank     [DEPTH];
    stream_state_t      state;
    stream_state_t      state_next;
    logic [IDX_W-1:0]   idx;
    logic               last_word;
    logic               send_word;
    pwm_result_t        result;

    logic [TIME_W-1:0]  pw_q;
    logic [PHASE_W-1:0] phase_q;
    logic               full_on_q;
    logic [IDX_W-1:0]   idx_q;
    logic               valid_q;
    logic               overrun_q;

    assign boundary  = (time_cnt == LAST_TIME);
    assign last_word = (idx == LAST_IDX);

    // One capture cell per observed channel.
    for (genvar ch = 0; ch < DEPTH; ch++) begin : g_cap
        pwm_edge_capture #(
            .LATENCY_COMP(LATENCY_COMP)
        ) u_cap (
            .clk      (clk),
            .rst      (rst),
            .time_cnt (time_cnt),
            .boundary (boundary),
            .pwm_in   (pwm_in[ch]),
            .cap_next (cap_next[ch])
        );
    end

    // Snapshot bank: frozen copy of every channel's record taken at the
    // boundary, so the stream reads a stable period while capture goes on.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                bank[i] <= '0;
            end
        end else if (boundary) begin
            for (int i = 0; i < DEPTH; i++) begin
                bank[i] <= cap_next[i];
            end
        end
    end

    // Stream FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Stream FSM next state: every boundary (re)starts a walk over all
    // channels; the walk ends after the last channel unless a boundary
    // restarts it in that same cycle.
    always_comb begin
        state_next = state;
        unique case (state)
            ST_IDLE: begin
                if (boundary) begin
                    state_next = ST_SEND;
                end
            end
            ST_SEND: begin
                if (!boundary && last_word) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Stream FSM outputs.
    always_comb begin
        send_word = (state == ST_SEND);
    end

    // Channel index walker; a boundary always rewinds to channel 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            idx <= '0;
        end else if (boundary) begin
            idx <= '0;
        end else if (send_word) begin
            idx <= last_word ? '0 : idx + IDX_W'(1);
        end
    end

    // Single shared decode unit on the selected bank entry.
    always_comb begin
        result = decode_capture(bank[idx]);
    end

    // Output pipeline register; data is zeroed whenever no word is sent.
    // Overrun latches a boundary seen mid-stream and only reset clears it.
    always_ff @(posedge clk) begin
        if (rst) begin
            pw_q      <= '0;
            phase_q   <= '0;
            full_on_q <= 1'b0;
            idx_q     <= '0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            valid_q <= send_word;
            if (send_word) begin
                pw_q      <= result.pulse_width;
                phase_q   <= result.phase;
                full_on_q <= result.full_on;
                idx_q     <= idx;
            end else begin
                pw_q      <= '0;
                phase_q   <= '0;
                full_on_q <= 1'b0;
                idx_q     <= '0;
            end
            if (boundary && send_word) begin
                overrun_q <= 1'b1;
            end
        end
    end

    assign dout.pulse_width_out = pw_q;
    assign dout.phase_out       = phase_q;
    assign dout.full_on_out     = full_on_q;
    assign dout.dout_idx        = idx_q;
    assign dout.dout_valid      = valid_q;
    assign dout.overrun         = overrun_q;

endmodule

// File: tb/tb_pwm_decoder.sv
// ----------------------------------------------------------------------------
// tb_pwm_decoder
// Drives two decoders (LATENCY_COMP = 0 and 1) from the same waveforms and
// scoreboards every streamed word against expectations queued per period.
// ----------------------------------------------------------------------------
module tb_pwm_decoder;
    import pwm_decoder_pkg::*;

    localparam int DEPTH = 249;

    logic              clk = 1'b0;
    logic              rst;
    logic [TIME_W-1:0] time_cnt;
    logic [DEPTH-1:0]  pwm_in;

    int tc;
    int n_cmp  = 0;
    int n_fail = 0;
    int n_valid;

    logic [25:0] exp_q0[$];
    logic [25:0] exp_q1[$];
    logic [25:0] w0;
    logic [25:0] w1;
    logic [25:0] mon_e0;
    logic [25:0] mon_e1;
    logic [27:0] flat0;
    logic [27:0] flat1;

    pwm_decoder_if bus0 ();
    pwm_decoder_if bus1 ();

    pwm_decoder #(.DEPTH(DEPTH), .LATENCY_COMP(0)) dut0 (
        .clk      (clk),
        .rst      (rst),
        .time_cnt (time_cnt),
        .pwm_in   (pwm_in),
        .dout     (bus0)
    );

    pwm_decoder #(.DEPTH(DEPTH), .LATENCY_COMP(1)) dut1 (
        .clk      (clk),
        .rst      (rst),
        .time_cnt (time_cnt),
        .pwm_in   (pwm_in),
        .dout     (bus1)
    );

    always #5 clk = ~clk;

    assign flat0 = {bus0.dout_valid, bus0.overrun, bus0.dout_idx,
                    bus0.pulse_width_out, bus0.phase_out, bus0.full_on_out};
    assign flat1 = {bus1.dout_valid, bus1.overrun, bus1.dout_idx,
                    bus1.pulse_width_out, bus1.phase_out, bus1.full_on_out};

    // Word layout {idx[7:0], pw[8:0], phase[7:0], full_on}.
    function automatic logic [25:0] pack_word(input int idx, input int pw, input int ph, input int fo);
        return {idx[7:0], pw[8:0], ph[7:0], fo[0]};
    endfunction

    // Reference decode from raw (already latency-compensated) edge times.
    function automatic logic [25:0] model_word(input int idx, input int rise, input int fall);
        int pw;
        int centre;
        pw     = (fall - rise) & 511;
        centre = (rise + pw / 2) & 511;
        return pack_word(idx, pw, centre / 2, 0);
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic checkWord(input string tag, input logic [25:0] obs, input logic [25:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("[TB] FAIL %s: observed idx=%0d pw=%0d ph=%0d fo=%0d expected idx=%0d pw=%0d ph=%0d fo=%0d",
                   tag, obs[25:18], obs[17:9], obs[8:1], obs[0], exp[25:18], exp[17:9], exp[8:1], exp[0]);
        end
    endtask

    // Advance one cycle: inputs change 1 time unit after the rising edge.
    task automatic applyStimulus();
        @(posedge clk);
        #1;
        tc       = (tc + 1) % 512;
        time_cnt = tc[8:0];
    endtask

    task automatic gotoTime(input int t);
        while (tc != t) applyStimulus();
    endtask

    // Scoreboard side: every valid word is popped and compared; an empty
    // queue yields an impossible word (idx 255) so stray words are caught.
    always @(negedge clk) begin
        if (bus0.dout_valid) begin
            if (exp_q0.size() > 0) mon_e0 = exp_q0.pop_front();
            else                   mon_e0 = '1;
            checkWord("dut0 stream word", {bus0.dout_idx, bus0.pulse_width_out, bus0.phase_out, bus0.full_on_out}, mon_e0);
        end
        if (bus1.dout_valid) begin
            if (exp_q1.size() > 0) mon_e1 = exp_q1.pop_front();
            else                   mon_e1 = '1;
            checkWord("dut1 stream word", {bus1.dout_idx, bus1.pulse_width_out, bus1.phase_out, bus1.full_on_out}, mon_e1);
        end
    end

    initial begin
        rst      = 1'b1;
        pwm_in   = '0;
        tc       = 0;
        time_cnt = '0;
        repeat (4) applyStimulus();
        checkOutput("dut0 reset outputs", 32'(flat0), 0);
        checkOutput("dut1 reset outputs", 32'(flat1), 0);
        rst = 1'b0;

        // Period 1: ch0 100..356, ch5 rises at 450, ch7 rises at 10 and stays up.
        $display("[TB] period 1: basic pulse, wrap start, full-on start");
        gotoTime(10);  pwm_in[7] = 1'b1;
        gotoTime(100); pwm_in[0] = 1'b1;
        gotoTime(356); pwm_in[0] = 1'b0;
        gotoTime(450); pwm_in[5] = 1'b1;
        for (int ch = 0; ch < DEPTH; ch++) begin
            w0 = pack_word(ch, 0, 0, 0);
            w1 = w0;
            case (ch)
                0: begin w0 = pack_word(0, 256, 114, 0); w1 = pack_word(0, 256, 113, 0); end
                5: begin w0 = model_word(5, 450, 0);     w1 = model_word(5, 449, 0);     end
                7: begin w0 = model_word(7, 10, 0);      w1 = model_word(7, 9, 0);       end
                default: ;
            endcase
            exp_q0.push_back(w0);
            exp_q1.push_back(w1);
        end
        gotoTime(511);
        applyStimulus();

        // Period 2: ch5 falls at 50 (wrap pulse), ch0 101..357, ch7 full-on.
        $display("[TB] period 2: wrap pulse, latency case, full-on/off");
        gotoTime(50);  pwm_in[5] = 1'b0;
        gotoTime(101); pwm_in[0] = 1'b1;
        gotoTime(357); pwm_in[0] = 1'b0;
        for (int ch = 0; ch < DEPTH; ch++) begin
            w0 = pack_word(ch, 0, 0, 0);
            w1 = w0;
            case (ch)
                0: begin w0 = pack_word(0, 256, 114, 0); w1 = pack_word(0, 256, 114, 0); end
                5: begin w0 = pack_word(5, 112, 253, 0); w1 = pack_word(5, 112, 252, 0); end
                7: begin w0 = pack_word(7, 511, 0, 1);   w1 = pack_word(7, 511, 0, 1);   end
                default: ;
            endcase
            exp_q0.push_back(w0);
            exp_q1.push_back(w1);
        end
        gotoTime(511);
        applyStimulus();
        pwm_in[7] = 1'b0;
        checkOutput("dut1 valid 1 cycle after boundary", 32'(bus1.dout_valid), 0);
        applyStimulus();
        checkOutput("dut1 valid 2 cycles after boundary", 32'(bus1.dout_valid), 1);
        checkOutput("dut1 first idx", 32'(bus1.dout_idx), 0);
        n_valid = 1;
        for (int k = 0; k < 600 && bus1.dout_valid; k++) begin
            applyStimulus();
            if (bus1.dout_valid) n_valid++;
        end
        checkOutput("dut1 valid run length", n_valid, DEPTH);

        // Period 3: every channel pulses 300..400 at once.
        $display("[TB] period 3: simultaneous edges on all channels");
        gotoTime(300); pwm_in = '1;
        gotoTime(400); pwm_in = '0;
        for (int ch = 0; ch <= 101; ch++) begin
            exp_q0.push_back(pack_word(ch, 100, 175, 0));
            exp_q1.push_back(pack_word(ch, 100, 174, 0));
        end
        for (int ch = 0; ch < DEPTH; ch++) begin
            exp_q0.push_back(pack_word(ch, 0, 0, 0));
            exp_q1.push_back(pack_word(ch, 0, 0, 0));
        end
        gotoTime(511);
        applyStimulus();

        // Forced early boundary while streaming idx 100 -> restart and overrun.
        $display("[TB] forced boundary mid-stream");
        gotoTime(101);
        checkOutput("dut1 idx before forced boundary", 32'(bus1.dout_idx), 100);
        checkOutput("dut0 overrun before forced boundary", 32'(bus0.overrun), 0);
        tc       = 511;
        time_cnt = 9'd511;
        applyStimulus();
        checkOutput("dut0 overrun set", 32'(bus0.overrun), 1);
        checkOutput("dut1 overrun set", 32'(bus1.overrun), 1);
        applyStimulus();
        checkOutput("dut1 idx restart", 32'(bus1.dout_idx), 0);
        checkOutput("dut1 valid across restart", 32'(bus1.dout_valid), 1);

        // Following period: ch3 pulses 400..450, then reset at idx 50.
        gotoTime(400); pwm_in[3] = 1'b1;
        gotoTime(450); pwm_in[3] = 1'b0;
        for (int ch = 0; ch < DEPTH; ch++) begin
            w0 = pack_word(ch, 0, 0, 0);
            w1 = w0;
            if (ch == 3) begin
                w0 = model_word(3, 400, 450);
                w1 = model_word(3, 399, 449);
            end
            exp_q0.push_back(w0);
            exp_q1.push_back(w1);
        end
        gotoTime(511);
        applyStimulus();
        $display("[TB] reset mid-stream");
        gotoTime(51);
        checkOutput("dut1 idx before reset", 32'(bus1.dout_idx), 50);
        checkOutput("dut1 overrun still sticky", 32'(bus1.overrun), 1);
        rst = 1'b1;
        applyStimulus();
        checkOutput("dut0 outputs after mid-stream reset", 32'(flat0), 0);
        checkOutput("dut1 outputs after mid-stream reset", 32'(flat1), 0);
        exp_q0.delete();
        exp_q1.delete();
        rst = 1'b0;

        // No new edges: next stream reports 0/0/0 for every channel.
        for (int ch = 0; ch < DEPTH; ch++) begin
            exp_q0.push_back(pack_word(ch, 0, 0, 0));
            exp_q1.push_back(pack_word(ch, 0, 0, 0));
        end
        gotoTime(511);
        applyStimulus();
        for (int k = 0; k < 400 && (exp_q0.size() > 0 || exp_q1.size() > 0); k++) begin
            applyStimulus();
        end
        applyStimulus();
        checkOutput("dut0 scoreboard drained", exp_q0.size(), 0);
        checkOutput("dut1 scoreboard drained", exp_q1.size(), 0);
        checkOutput("dut1 valid after stream", 32'(bus1.dout_valid), 0);
        checkOutput("dut1 overrun after reset", 32'(bus1.overrun), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
